// File: rtl/hmlf_pkg.sv
// Shared constants and elaboration helpers for the HMLF min/max selection tree.
package hmlf_pkg;

  typedef enum logic {
    MODE_MIN = 1'b0,
    MODE_MAX = 1'b1
  } hmlf_mode_e;

  // Ceiling log2 for tools that lack $clog2 in constant contexts.
  function automatic int hmlf_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int hmlf_lvl_cnt(input int n, input int lvl);
    return (n + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic int hmlf_lvl_off(input int n, input int lvl);
    int o;
    o = 0;
    for (int i = 1; i < lvl; i++) o += hmlf_lvl_cnt(n, i);
    return o;
  endfunction

endpackage

// File: rtl/hmlf_minmax_tree_if.sv
// Vector-in / winner-out bundle of the min/max tree; master drives vectors, slave is the tree.
interface hmlf_minmax_tree_if #(
  parameter int WIDTH = 6,
  parameter int N_IN  = 8
);
  import hmlf_pkg::*;

  localparam int IDX_W = hmlf_clog2(N_IN);

  logic                    in_valid;
  logic                    in_mode;
  logic [N_IN*WIDTH-1:0]   in_data;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic [IDX_W-1:0]        out_idx;

  modport master (
    output in_valid, in_mode, in_data,
    input  out_valid, out_data, out_idx
  );

  modport slave (
    input  in_valid, in_mode, in_data,
    output out_valid, out_data, out_idx
  );

endinterface

// File: rtl/hmlf_cmp2_sel.sv
// Two-operand signed min/max select; operand a is the lower-index one and wins ties.
module hmlf_cmp2_sel #(
  parameter int WIDTH = 6,
  parameter int IDX_W = 3
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic [IDX_W-1:0]        i_ia,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic [IDX_W-1:0]        i_ib,
  input  logic                    i_mode,
  output logic signed [WIDTH-1:0] o_y,
  output logic [IDX_W-1:0]        o_iy
);
  import hmlf_pkg::*;

  logic w_pick_b;

  // Strict compares keep equal values on a, which matches the legacy 2-input MIN.
  assign w_pick_b = (i_mode == MODE_MAX) ? (i_b > i_a) : (i_b < i_a);
  assign o_y      = w_pick_b ? i_b  : i_a;
  assign o_iy     = w_pick_b ? i_ib : i_ia;

endmodule

// File: rtl/hmlf_minmax_tree.sv
// Pipelined N-input signed min/max selector with winner index; one register stage per tree level.
module hmlf_minmax_tree #(
  parameter int WIDTH = 6,
  parameter int N_IN  = 8
) (
  input  logic               clk,
  input  logic               rst,
  hmlf_minmax_tree_if.slave  bus
);
  import hmlf_pkg::*;

  localparam int IDX_W   = hmlf_clog2(N_IN);
  localparam int LAT     = hmlf_clog2(N_IN);
  localparam int TOTAL   = hmlf_lvl_off(N_IN, LAT + 1);
  localparam int OUT_POS = hmlf_lvl_off(N_IN, LAT);

  // Flat storage of all levels; level j starts at hmlf_lvl_off(N_IN, j).
  logic signed [WIDTH-1:0] w_y   [TOTAL];
  logic [IDX_W-1:0]        w_iy  [TOTAL];
  logic signed [WIDTH-1:0] r_val [TOTAL];
  logic [IDX_W-1:0]        r_idx [TOTAL];
  logic [LAT:1]            r_vld;
  logic [LAT-1:0]          w_mode;

  assign w_mode[0] = bus.in_mode;

  // The last level needs no mode, so the mode pipe is one stage shorter than valid.
  if (LAT > 1) begin : g_mode
    logic [LAT-1:1] r_mode;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_mode <= '0;
      else     r_mode <= w_mode[LAT-2:0];
    end
    assign w_mode[LAT-1:1] = r_mode;
  end

  for (genvar j = 1; j <= LAT; j++) begin : g_lvl
    localparam int PCNT = hmlf_lvl_cnt(N_IN, j - 1);
    localparam int CNT  = hmlf_lvl_cnt(N_IN, j);
    localparam int O    = hmlf_lvl_off(N_IN, j);

    for (genvar k = 0; k < CNT; k++) begin : g_el
      logic signed [WIDTH-1:0] w_a;
      logic [IDX_W-1:0]        w_ia;

      if (j == 1) begin : g_a_in
        assign w_a  = bus.in_data[2*k*WIDTH +: WIDTH];
        assign w_ia = IDX_W'(2 * k);
      end else begin : g_a_reg
        assign w_a  = r_val[hmlf_lvl_off(N_IN, j - 1) + 2*k];
        assign w_ia = r_idx[hmlf_lvl_off(N_IN, j - 1) + 2*k];
      end

      if (2*k + 1 < PCNT) begin : g_pair
        logic signed [WIDTH-1:0] w_b;
        logic [IDX_W-1:0]        w_ib;

        if (j == 1) begin : g_b_in
          assign w_b  = bus.in_data[(2*k+1)*WIDTH +: WIDTH];
          assign w_ib = IDX_W'(2*k + 1);
        end else begin : g_b_reg
          assign w_b  = r_val[hmlf_lvl_off(N_IN, j - 1) + 2*k + 1];
          assign w_ib = r_idx[hmlf_lvl_off(N_IN, j - 1) + 2*k + 1];
        end

        hmlf_cmp2_sel #(
          .WIDTH (WIDTH),
          .IDX_W (IDX_W)
        ) u_cmp (
          .i_a    (w_a),
          .i_ia   (w_ia),
          .i_b    (w_b),
          .i_ib   (w_ib),
          .i_mode (w_mode[j-1]),
          .o_y    (w_y[O+k]),
          .o_iy   (w_iy[O+k])
        );
      end else begin : g_pass
        // Unpaired top element rides through with its own index; no padding value.
        assign w_y[O+k]  = w_a;
        assign w_iy[O+k] = w_ia;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the level arrays are real pipeline flops (not RAM), so they are cleared on reset too.
      for (int i = 0; i < TOTAL; i++) begin
        r_val[i] <= '0;
        r_idx[i] <= '0;
      end
      r_vld <= '0;
    end else begin
      r_val    <= w_y;
      r_idx    <= w_iy;
      r_vld[1] <= bus.in_valid;
      for (int j = 2; j <= LAT; j++) r_vld[j] <= r_vld[j-1];
    end
  end

  assign bus.out_valid = r_vld[LAT];
  assign bus.out_data  = r_val[OUT_POS];
  assign bus.out_idx   = r_idx[OUT_POS];

endmodule
